// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: funct3 access codes,
// FSM states and byte-lane mask constants.
package mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;
  localparam logic [2:0] F3_SD = 3'd3;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // funct3[1:0] is the log2 access size for both loads and stores
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = MASK_B;
      2'd1:    m = MASK_H;
      2'd2:    m = MASK_W;
      default: m = MASK_D;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatting: store shift/mask, load extract/extend,
// and misalignment/illegal-encoding detection.
module mem_lane_fmt
  import mem_stage_pkg::*;
(
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [2:0]  off_i,
  input  logic [63:0] sdata_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  wmask_o,
  output logic [63:0] ldata_o,
  output logic        fault_o
);

  logic [1:0]  size;
  logic [5:0]  shamt;
  logic [63:0] field_w;
  logic        illegal;
  logic        misal;

  always_comb begin
    size    = funct3_i[1:0];
    shamt   = {off_i, 3'b000};
    illegal = (load_i && store_i) ||
              (load_i && funct3_i == 3'd7) ||
              (store_i && funct3_i[2]);
    case (size)
      2'd0:    misal = 1'b0;
      2'd1:    misal = off_i[0];
      2'd2:    misal = |off_i[1:0];
      default: misal = |off_i;
    endcase
    fault_o = (load_i || store_i) && (illegal || misal);

    wdata_o = sdata_i << shamt;
    wmask_o = store_i ? (size_mask(size) << off_i) : 8'h00;

    field_w = rdata_i >> shamt;
    case (funct3_i)
      F3_LB:   ldata_o = {{56{field_w[7]}},  field_w[7:0]};
      F3_LH:   ldata_o = {{48{field_w[15]}}, field_w[15:0]};
      F3_LW:   ldata_o = {{32{field_w[31]}}, field_w[31:0]};
      F3_LBU:  ldata_o = {56'd0, field_w[7:0]};
      F3_LHU:  ldata_o = {48'd0, field_w[15:0]};
      F3_LWU:  ldata_o = {32'd0, field_w[31:0]};
      default: ldata_o = field_w;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: request/response handshake to a 64-bit data
// memory, upstream stall while busy, and the registered MEM/WB boundary.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned XLEN   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   sdata_i,
  input  logic [XLEN-1:0]   aluout_i,
  input  logic              wen_i,
  input  logic [4:0]        rd_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              exit_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_req_wen_o,
  output logic [XLEN-1:0]   mem_req_wdata_o,
  output logic [7:0]        mem_req_wmask_o,
  input  logic              mem_resp_valid_i,
  input  logic [XLEN-1:0]   mem_resp_rdata_i,
  output logic              mem_not_ready_o,
  output logic              wb_valid_o,
  output logic              wb_wen_o,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic [XLEN-1:0]   wb_pc_o,
  output logic              wb_exit_o,
  output logic              fault_o
);

  state_e            state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_wen_q, wb_wen_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [XLEN-1:0]   wb_pc_q, wb_pc_d;
  logic              wb_exit_q, wb_exit_d;
  logic              fault_q, fault_d;

  logic              is_mem;
  logic              lane_fault;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   aligned_addr;

  mem_lane_fmt u_fmt (
    .load_i   (load_i),
    .store_i  (store_i),
    .funct3_i (funct3_i),
    .off_i    (aluout_i[2:0]),
    .sdata_i  (sdata_i),
    .rdata_i  (mem_resp_rdata_i),
    .wdata_o  (mem_req_wdata_o),
    .wmask_o  (mem_req_wmask_o),
    .ldata_o  (load_data),
    .fault_o  (lane_fault)
  );

  // Payload is a pure function of the held EX inputs, so it stays stable in REQ
  assign is_mem         = load_i || store_i;
  assign aligned_addr   = {aluout_i[XLEN-1:3], 3'b000};
  assign mem_req_addr_o = aligned_addr[ADDR_W-1:0];
  assign mem_req_wen_o  = store_i;

  always_comb begin
    state_d         = state_q;
    wb_valid_d      = 1'b0;
    fault_d         = 1'b0;
    wb_wen_d        = wb_wen_q;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    wb_pc_d         = wb_pc_q;
    wb_exit_d       = wb_exit_q;
    mem_req_valid_o = 1'b0;
    mem_not_ready_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (!is_mem || lane_fault) begin
            wb_valid_d = 1'b1;
            fault_d    = is_mem;
            wb_wen_d   = is_mem ? 1'b0 : wen_i;
            wb_rd_d    = rd_i;
            wb_data_d  = is_mem ? '0 : aluout_i;
            wb_pc_d    = pc_i;
            wb_exit_d  = exit_i;
          end else begin
            state_d         = ST_REQ;
            mem_not_ready_o = 1'b1;
          end
        end
      end
      ST_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_not_ready_o = 1'b1;
        if (mem_req_ready_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid_i) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_wen_d   = load_i && wen_i;
          wb_rd_d    = rd_i;
          wb_data_d  = load_i ? load_data : '0;
          wb_pc_d    = pc_i;
          wb_exit_d  = exit_i;
        end else begin
          mem_not_ready_o = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wb_valid_q <= 1'b0;
      wb_wen_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_pc_q    <= '0;
      wb_exit_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_wen_q   <= wb_wen_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_pc_q    <= wb_pc_d;
      wb_exit_q  <= wb_exit_d;
      fault_q    <= fault_d;
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_wen_o   = wb_wen_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign wb_pc_o    = wb_pc_q;
  assign wb_exit_o  = wb_exit_q;
  assign fault_o    = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scenario tasks drive EX/memory stimulus and push the
// expected writeback into a scoreboard popped whenever wb_valid_o is seen.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_i, load_i, store_i, wen_i, exit_i;
  logic [2:0]  funct3_i;
  logic [63:0] sdata_i, aluout_i, pc_i;
  logic [4:0]  rd_i;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_wen_o;
  logic [63:0] mem_req_addr_o, mem_req_wdata_o;
  logic [7:0]  mem_req_wmask_o;
  logic        mem_resp_valid_i;
  logic [63:0] mem_resp_rdata_i;
  logic        mem_not_ready_o;
  logic        wb_valid_o, wb_wen_o, wb_exit_o, fault_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_data_o, wb_pc_o;

  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        chk_data;
    logic [63:0] pc;
    logic        ex;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_stage dut (
    .clock            (clock),
    .reset            (reset),
    .valid_i          (valid_i),
    .load_i           (load_i),
    .store_i          (store_i),
    .funct3_i         (funct3_i),
    .sdata_i          (sdata_i),
    .aluout_i         (aluout_i),
    .wen_i            (wen_i),
    .rd_i             (rd_i),
    .pc_i             (pc_i),
    .exit_i           (exit_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_wen_o    (mem_req_wen_o),
    .mem_req_wdata_o  (mem_req_wdata_o),
    .mem_req_wmask_o  (mem_req_wmask_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_rdata_i (mem_resp_rdata_i),
    .mem_not_ready_o  (mem_not_ready_o),
    .wb_valid_o       (wb_valid_o),
    .wb_wen_o         (wb_wen_o),
    .wb_rd_o          (wb_rd_o),
    .wb_data_o        (wb_data_o),
    .wb_pc_o          (wb_pc_o),
    .wb_exit_o        (wb_exit_o),
    .fault_o          (fault_o)
  );

  // Scoreboard consumer: every completed instruction must match the oldest entry
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset === 1'b1 && wb_valid_o === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got wb_valid_o=1 pc=%h, required no completion", wb_pc_o);
      end else begin
        e = sb_q.pop_front();
        total++;
        if (wb_wen_o !== e.wen) begin
          bad++; $display("FAIL wb_wen pc=%h: got %b required %b", e.pc, wb_wen_o, e.wen);
        end
        if (e.wen) begin
          total++;
          if (wb_rd_o !== e.rd) begin
            bad++; $display("FAIL wb_rd pc=%h: got %0d required %0d", e.pc, wb_rd_o, e.rd);
          end
        end
        if (e.chk_data) begin
          total++;
          if (wb_data_o !== e.data) begin
            bad++; $display("FAIL wb_data pc=%h: got %h required %h", e.pc, wb_data_o, e.data);
          end
        end
        total += 3;
        if (wb_pc_o !== e.pc) begin
          bad++; $display("FAIL wb_pc: got %h required %h", wb_pc_o, e.pc);
        end
        if (wb_exit_o !== e.ex) begin
          bad++; $display("FAIL wb_exit pc=%h: got %b required %b", e.pc, wb_exit_o, e.ex);
        end
        if (fault_o !== e.fault) begin
          bad++; $display("FAIL wb_fault pc=%h: got %b required %b", e.pc, fault_o, e.fault);
        end
        $display("completed pc=%h wen=%b rd=%0d data=%h exit=%b fault=%b",
                 wb_pc_o, wb_wen_o, wb_rd_o, wb_data_o, wb_exit_o, fault_o);
      end
    end
  end

  task automatic set_idle();
    valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0; wen_i = 1'b0; exit_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_idle();
    funct3_i = 3'd0; sdata_i = '0; aluout_i = '0; pc_i = '0; rd_i = '0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_rdata_i = '0;
    repeat (3) @(negedge clock);
    #1;
    total += 5;
    if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL reset_wb_valid: got %b required 0", wb_valid_o); end
    if (fault_o !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b required 0", fault_o); end
    if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b required 0", mem_req_valid_o); end
    if (wb_data_o !== 64'd0) begin bad++; $display("FAIL reset_wb_data: got %h required 0", wb_data_o); end
    if (mem_not_ready_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b required 0", mem_not_ready_o); end
    $display("reset checked");
    reset = 1'b1;
  endtask

  task automatic test_alu_back_to_back();
    logic [63:0] res [3] = '{64'h1234, 64'hCAFE_0000_0000_0001, 64'h0};
    logic [4:0]  rds [3] = '{5'd5, 5'd31, 5'd1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      valid_i = 1'b1; load_i = 1'b0; store_i = 1'b0; funct3_i = 3'd0;
      aluout_i = res[i]; wen_i = 1'b1; rd_i = rds[i]; pc_i = 64'h100 + 64'(4 * i);
      exit_i = (i == 2);
      #1;
      sb_q.push_back('{wen: 1'b1, rd: rds[i], data: res[i], chk_data: 1'b1,
                       pc: 64'h100 + 64'(4 * i), ex: (i == 2), fault: 1'b0});
      total += 2;
      if (mem_not_ready_o !== 1'b0) begin bad++; $display("FAIL alu_stall[%0d]: got %b required 0", i, mem_not_ready_o); end
      if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL alu_req[%0d]: got %b required 0", i, mem_req_valid_o); end
      $display("alu issue pc=%h result=%h", pc_i, res[i]);
    end
    @(negedge clock);
    set_idle();
    total++;
    if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL alu_latency: got wb_valid_o=%b required 1", wb_valid_o); end
    @(negedge clock);
    total++;
    if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL alu_bubble: got wb_valid_o=%b required 0", wb_valid_o); end
  endtask

  task automatic do_mem_op(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] sd,
                           input logic [63:0] rdata, input int rdy_dly, input int resp_dly,
                           input logic [7:0] exp_mask, input logic [63:0] exp_wdata,
                           input logic [63:0] exp_ldata, input logic [63:0] pc);
    @(negedge clock);
    valid_i = 1'b1; load_i = ld; store_i = st; funct3_i = f3; aluout_i = addr;
    sdata_i = sd; wen_i = ld; rd_i = 5'd9; pc_i = pc; exit_i = 1'b0;
    #1;
    sb_q.push_back('{wen: ld, rd: 5'd9, data: exp_ldata, chk_data: ld,
                     pc: pc, ex: 1'b0, fault: 1'b0});
    total += 2;
    if (mem_not_ready_o !== 1'b1) begin bad++; $display("FAIL mem_entry_stall pc=%h: got %b required 1", pc, mem_not_ready_o); end
    if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL mem_entry_req pc=%h: got %b required 0", pc, mem_req_valid_o); end
    for (int i = 0; i <= rdy_dly; i++) begin
      @(negedge clock);
      mem_req_ready_i = (i == rdy_dly);
      #1;
      total += 5;
      if (mem_req_valid_o !== 1'b1) begin bad++; $display("FAIL req_valid pc=%h: got %b required 1", pc, mem_req_valid_o); end
      if (mem_req_addr_o !== (addr & ~64'h7)) begin bad++; $display("FAIL req_addr pc=%h: got %h required %h", pc, mem_req_addr_o, addr & ~64'h7); end
      if (mem_req_wen_o !== st) begin bad++; $display("FAIL req_wen pc=%h: got %b required %b", pc, mem_req_wen_o, st); end
      if (mem_req_wmask_o !== exp_mask) begin bad++; $display("FAIL req_wmask pc=%h: got %h required %h", pc, mem_req_wmask_o, exp_mask); end
      if (mem_not_ready_o !== 1'b1) begin bad++; $display("FAIL req_stall pc=%h: got %b required 1", pc, mem_not_ready_o); end
      if (st) begin
        total++;
        if (mem_req_wdata_o !== exp_wdata) begin bad++; $display("FAIL req_wdata pc=%h: got %h required %h", pc, mem_req_wdata_o, exp_wdata); end
      end
    end
    for (int j = 0; j <= resp_dly; j++) begin
      @(negedge clock);
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = (j == resp_dly);
      mem_resp_rdata_i = (j == resp_dly) ? rdata : {$urandom(), $urandom()};
      #1;
      total += 3;
      if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL wait_req pc=%h: got %b required 0", pc, mem_req_valid_o); end
      if (mem_not_ready_o !== (j != resp_dly)) begin bad++; $display("FAIL wait_stall pc=%h cyc=%0d: got %b required %b", pc, j, mem_not_ready_o, j != resp_dly); end
      if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL wait_early_wb pc=%h: got %b required 0", pc, wb_valid_o); end
    end
    @(negedge clock);
    mem_resp_valid_i = 1'b0;
    set_idle();
    #1;
    total += 2;
    if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL mem_complete pc=%h: got wb_valid_o=%b required 1", pc, wb_valid_o); end
    if (mem_not_ready_o !== 1'b0) begin bad++; $display("FAIL mem_after_stall pc=%h: got %b required 0", pc, mem_not_ready_o); end
    $display("mem op pc=%h ld=%b st=%b f3=%0d addr=%h done", pc, ld, st, f3, addr);
  endtask

  task automatic test_loads();
    do_mem_op(1, 0, 3'd0, 64'h1003, 64'h0, 64'h00000000_80000000, 0, 0, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFF80, 64'h200);
    do_mem_op(1, 0, 3'd4, 64'h1003, 64'h0, 64'h00000000_80000000, 0, 0, 8'h00, 64'h0, 64'h80, 64'h204);
    do_mem_op(1, 0, 3'd1, 64'h5006, 64'h0, 64'hFEDC0000_00000000, 0, 1, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFEDC, 64'h208);
    do_mem_op(1, 0, 3'd5, 64'h5006, 64'h0, 64'hFEDC0000_00000000, 1, 0, 8'h00, 64'h0, 64'h0000FEDC, 64'h20C);
    do_mem_op(1, 0, 3'd2, 64'h3004, 64'h0, 64'h80000000_12345678, 0, 0, 8'h00, 64'h0, 64'hFFFFFFFF_80000000, 64'h210);
    do_mem_op(1, 0, 3'd6, 64'h3004, 64'h0, 64'h80000000_12345678, 0, 0, 8'h00, 64'h0, 64'h80000000, 64'h214);
  endtask

  task automatic test_stores();
    do_mem_op(0, 1, 3'd1, 64'h2002, 64'hBEEF, 64'h0, 0, 0, 8'h0C, 64'h00000000_BEEF0000, 64'h0, 64'h300);
    do_mem_op(0, 1, 3'd2, 64'h6004, 64'h11223344, 64'h0, 0, 1, 8'hF0, 64'h11223344_00000000, 64'h0, 64'h304);
    do_mem_op(0, 1, 3'd0, 64'h7007, 64'h12AB, 64'h0, 1, 0, 8'h80, 64'hAB000000_00000000, 64'h0, 64'h308);
    do_mem_op(0, 1, 3'd3, 64'h8000, 64'hDEADBEEF_CAFEF00D, 64'h0, 1, 2, 8'hFF, 64'hDEADBEEF_CAFEF00D, 64'h0, 64'h30C);
  endtask

  task automatic test_ld_stall();
    do_mem_op(1, 0, 3'd3, 64'h4000, 64'h0, 64'h01234567_89ABCDEF, 4, 3, 8'h00, 64'h0, 64'h01234567_89ABCDEF, 64'h400);
  endtask

  task automatic test_faults();
    logic        lds [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        sts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3s [6] = '{3'd2, 3'd7, 3'd4, 3'd3, 3'd3, 3'd1};
    logic [63:0] ads [6] = '{64'h3001, 64'h3000, 64'h3000, 64'h3000, 64'h3004, 64'h3005};
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i > 0) begin
        total++;
        if (fault_o !== 1'b1) begin bad++; $display("FAIL fault_pulse[%0d]: got %b required 1", i - 1, fault_o); end
      end
      valid_i = 1'b1; load_i = lds[i]; store_i = sts[i]; funct3_i = f3s[i];
      aluout_i = ads[i]; wen_i = 1'b1; rd_i = 5'd7; pc_i = 64'h500 + 64'(4 * i); exit_i = 1'b0;
      #1;
      sb_q.push_back('{wen: 1'b0, rd: 5'd7, data: 64'h0, chk_data: 1'b0,
                       pc: 64'h500 + 64'(4 * i), ex: 1'b0, fault: 1'b1});
      total += 2;
      if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL fault_req[%0d]: got %b required 0", i, mem_req_valid_o); end
      if (mem_not_ready_o !== 1'b0) begin bad++; $display("FAIL fault_stall[%0d]: got %b required 0", i, mem_not_ready_o); end
      $display("fault issue pc=%h ld=%b st=%b f3=%0d addr=%h", pc_i, lds[i], sts[i], f3s[i], ads[i]);
    end
    @(negedge clock);
    total++;
    if (fault_o !== 1'b1) begin bad++; $display("FAIL fault_pulse[5]: got %b required 1", fault_o); end
    set_idle();
    @(negedge clock);
    total += 2;
    if (fault_o !== 1'b0) begin bad++; $display("FAIL fault_clear: got %b required 0", fault_o); end
    if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL fault_no_req: got %b required 0", mem_req_valid_o); end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clock);
    valid_i = 1'b1; load_i = 1'b1; store_i = 1'b0; funct3_i = 3'd3;
    aluout_i = 64'h9000; wen_i = 1'b1; rd_i = 5'd3; pc_i = 64'h600; exit_i = 1'b0;
    @(negedge clock);
    mem_req_ready_i = 1'b1;
    @(negedge clock);
    mem_req_ready_i = 1'b0;
    #1;
    total++;
    if (mem_not_ready_o !== 1'b1) begin bad++; $display("FAIL rw_in_wait: got stall=%b required 1", mem_not_ready_o); end
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    set_idle();
    #1;
    total += 2;
    if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rw_reset_wb: got %b required 0", wb_valid_o); end
    if (mem_not_ready_o !== 1'b0) begin bad++; $display("FAIL rw_reset_stall: got %b required 0", mem_not_ready_o); end
    @(negedge clock);
    mem_resp_valid_i = 1'b1;
    mem_resp_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
    #1;
    total += 2;
    if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL rw_stale_req: got %b required 0", mem_req_valid_o); end
    if (mem_not_ready_o !== 1'b0) begin bad++; $display("FAIL rw_stale_stall: got %b required 0", mem_not_ready_o); end
    @(negedge clock);
    mem_resp_valid_i = 1'b0;
    #1;
    total += 2;
    if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rw_stale_wb: got %b required 0", wb_valid_o); end
    if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL rw_idle_req: got %b required 0", mem_req_valid_o); end
    $display("reset in WAIT with stale response checked");
    // Idle machine must still accept a fresh op after the flush
    do_mem_op(1, 0, 3'd0, 64'h9001, 64'h0, 64'h00000000_00007F00, 0, 0, 8'h00, 64'h0, 64'h7F, 64'h604);
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_loads();
    test_stores();
    test_ld_stall();
    test_faults();
    test_reset_in_wait();
    repeat (2) @(negedge clock);
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage sitting directly downstream of the execute stage.
- Consumes the EX outputs: load/store flags, funct3, store data, ALU result used as address or writeback value, rd, wen, pc, exit.
- Runs a request/response handshake to a 64-bit data memory, with byte-lane store masks and load sign/zero extension.
- Registers the result into the MEM/WB boundary and stalls upstream while a memory access is outstanding.

Parameters:
- ADDR_W, 64, address width driven to data memory
- XLEN, 64, datapath width; only 64 is supported

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- valid_i  in  1  EX holds a valid instruction
- load_i  in  1  instruction is a load
- store_i  in  1  instruction is a store
- funct3_i  in  3  access size/sign
- sdata_i  in  64  store data, right-aligned
- aluout_i  in  64  address (load/store) or result (others)
- wen_i  in  1  register write enable
- rd_i  in  5  destination register
- pc_i  in  64  debug pc
- exit_i  in  1  simulation-exit marker
- mem_req_valid_o  out  1  request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  64  doubleword-aligned address ({addr[63:3],3'b0})
- mem_req_wen_o  out  1  1 = store
- mem_req_wdata_o  out  64  lane-shifted store data
- mem_req_wmask_o  out  8  byte-lane mask
- mem_resp_valid_i  in  1  read data / store ack valid
- mem_resp_rdata_i  in  64  read doubleword
- mem_not_ready_o  out  1  stall request to upstream stages
- wb_valid_o  out  1  registered: result valid
- wb_wen_o  out  1  registered
- wb_rd_o  out  5  registered
- wb_data_o  out  64  registered writeback data
- wb_pc_o  out  64  registered
- wb_exit_o  out  1  registered
- fault_o  out  1  registered one-cycle pulse: misaligned or illegal access

Behaviour:
- Reset (reset==0 at posedge): FSM to IDLE. All wb_* outputs and fault_o go to 0. mem_req_valid_o=0. Any in-flight response is discarded: a mem_resp_valid_i received in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- Non-memory op (valid_i & !load_i & !store_i): no stall. wb_* is loaded next edge with wb_data_o=aluout_i. Latency 1.
- IDLE, valid aligned memory op: go to REQ. mem_not_ready_o=1 combinationally from this cycle.
- REQ: mem_req_valid_o=1, with addr/wen/wdata/wmask derived from the held inputs. On mem_req_ready_i, go to WAIT. mem_req_valid_o must stay high with stable payload until accepted.
- WAIT: on mem_resp_valid_i, mem_not_ready_o drops that same cycle and wb_* loads at that edge; return to IDLE. A response in the same cycle as acceptance is not allowed; it is only accepted in WAIT.
- Upstream must hold all *_i stable while mem_not_ready_o=1.
- wb_valid_o is 0 on every edge where no instruction completes (bubble).
- Memory-op latency: minimum 3 edges from entry (IDLE→REQ→WAIT→capture).
- Load formatting:
  - off=aluout_i[2:0]; the selected field is rdata >> (8*off).
  - funct3 0/1/2/3 = LB/LH/LW/LD, sign-extended.
  - funct3 4/5/6 = LBU/LHU/LWU, zero-extended.
- Store formatting:
  - funct3 0/1/2/3 = SB/SH/SW/SD.
  - wdata = sdata_i << (8*off).
  - wmask = {1,3,15,255}[size] << off.
  - Store completion: wb_wen_o=0, wb_valid_o=1.
- Misaligned (LH/SH with off[0]≠0; LW/SW with off[1:0]≠0; LD/SD with off≠0) or illegal (load funct3=7, store funct3>3):
  - No memory request, no stall.
  - Next edge: fault_o=1, wb_valid_o=1, wb_wen_o=0, wb_pc_o=pc_i.
- load_i & store_i both set is illegal: fault path.
- exit_i passes through to wb_exit_o with its instruction.

Decomposition:
- Shared package/define file: funct3 encodings (LB..LWU, SB..SD), FSM state encodings, and size-to-mask constants.
- One natural sub-module, mem_lane_fmt: purely combinational store-lane shifting/masking, load extraction/extension, and alignment check. The FSM and registers stay in mem_stage.

Test Plan:
- ADD result 0x1234, wen=1, rd=5 → next edge wb_data_o=0x1234, wb_rd_o=5, mem_not_ready_o never high.
- LB addr 0x1003, rdata 0x00000000_80000000 → byte 0x80 → wb_data_o=0xFFFFFFFFFFFFFF80. LBU same → 0x80. Request addr 0x1000.
- SH addr 0x2002, sdata 0xBEEF → wdata 0x00000000_BEEF0000, wmask 0x0C, wen=1. wb_wen_o=0 after the ack.
- LW addr 0x3001 → fault_o pulse, no mem_req_valid_o, wb_wen_o=0, no stall.
- LD with mem_req_ready_i low for 4 cycles, then response delayed 3 cycles → request payload stable throughout, mem_not_ready_o high until the response cycle, wb_data_o = rdata.
- reset=0 asserted in WAIT, then a stale mem_resp_valid_i after release → ignored: wb_valid_o=0, FSM in IDLE.
